// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU operation codes and decode helpers for the controller, the
// result calculator and the instruction decoder.
package mdu_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_md_start(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic logic is_md_move(input logic [3:0] op);
        return (op == 4'd5) || (op == 4'd6);
    endfunction

    function automatic logic is_md_div(input logic [3:0] op);
        return (op == 4'd3) || (op == 4'd4);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage issue / D-stage stall / HI-LO read bundle between the pipeline
// (master) and the multiply/divide controller (slave).
interface mdu_ctrl_if;
    logic [3:0]  mdop_E;
    logic        cancel_E;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic        mduse_D;
    logic        busy;
    logic        stall_D;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output mdop_E, cancel_E, RS_E, RT_E, mduse_D,
        input  busy, stall_D, HI, LO
    );

    modport slave (
        input  mdop_E, cancel_E, RS_E, RT_E, mduse_D,
        output busy, stall_D, HI, LO
    );
endinterface

// File: rtl/mdu_calc.sv
// Combinational mult/div result generator: {hi,lo} for the given op plus a
// hold flag that tells the controller to leave HI/LO untouched (divide by 0).
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hold
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic               div_zero;
    logic               div_ovf;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] squo;
    logic signed [31:0] srem;
    logic        [31:0] ub;
    logic        [31:0] uquo;
    logic        [31:0] urem;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    assign div_zero = (b == 32'd0);
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // A divisor of 1 gives exactly the required overflow result (q=a, r=0)
    // and keeps the dividers away from a zero divisor.
    assign sa   = a;
    assign sb   = (div_zero || div_ovf) ? 32'sd1 : b;
    assign squo = sa / sb;
    assign srem = sa % sb;

    assign ub   = div_zero ? 32'd1 : b;
    assign uquo = a / ub;
    assign urem = a % ub;

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        hold = 1'b0;
        case (op)
            MD_MULT:  {hi, lo} = sprod;
            MD_MULTU: {hi, lo} = uprod;
            MD_DIV: begin
                hi   = srem;
                lo   = squo;
                hold = div_zero;
            end
            MD_DIVU: begin
                hi   = urem;
                lo   = uquo;
                hold = div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, times iterative mult/div with a
// down-counter and stalls the D stage while an operation is in flight.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no operation in flight; E-stage start or mthi/mtlo accepted
//   ST_BUSY | counting down; HI/LO <= pending result when counter hits 1
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    mdu_ctrl_if.slave     mdu
);

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      hi_q, hi_next;
    logic [31:0]      lo_q, lo_next;
    logic [31:0]      pend_hi, pend_hi_next;
    logic [31:0]      pend_lo, pend_lo_next;
    logic             pend_hold, pend_hold_next;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;
    logic             calc_hold;
    logic             busy;
    logic             start;
    logic             mtw;

    mdu_calc u_calc (
        .op   (mdu.mdop_E),
        .a    (mdu.RS_E),
        .b    (mdu.RT_E),
        .hi   (calc_hi),
        .lo   (calc_lo),
        .hold (calc_hold)
    );

    assign busy  = (state == ST_BUSY);
    assign start = is_md_start(mdu.mdop_E) && !mdu.cancel_E && !busy;
    assign mtw   = is_md_move(mdu.mdop_E) && !mdu.cancel_E && !busy;

    // Covers the start cycle too, so the next HI/LO user never enters E.
    assign mdu.stall_D = mdu.mduse_D &&
                         (busy || (is_md_start(mdu.mdop_E) && !mdu.cancel_E));
    assign mdu.busy    = busy;
    assign mdu.HI      = hi_q;
    assign mdu.LO      = lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_hold <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            hi_q      <= hi_next;
            lo_q      <= lo_next;
            pend_hi   <= pend_hi_next;
            pend_lo   <= pend_lo_next;
            pend_hold <= pend_hold_next;
        end
    end

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        hi_next        = hi_q;
        lo_next        = lo_q;
        pend_hi_next   = pend_hi;
        pend_lo_next   = pend_lo;
        pend_hold_next = pend_hold;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next     = ST_BUSY;
                    cnt_next       = is_md_div(mdu.mdop_E) ? CNT_W'(DIV_CYCLES)
                                                           : CNT_W'(MULT_CYCLES);
                    pend_hi_next   = calc_hi;
                    pend_lo_next   = calc_lo;
                    pend_hold_next = calc_hold;
                end else if (mtw) begin
                    if (mdu.mdop_E == MD_MTHI) hi_next = mdu.RS_E;
                    else                       lo_next = mdu.RS_E;
                end
            end
            ST_BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    if (!pend_hold) begin
                        hi_next = pend_hi;
                        lo_next = pend_lo;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of mult/div vectors plus hand-written
// stall, cancel, move and reset-abort sequences.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // The stall should keep any MDU op out of E while busy.
    always @(negedge clk) begin
        if (!reset && bus.busy && !bus.cancel_E &&
            (is_md_start(bus.mdop_E) || is_md_move(bus.mdop_E))) begin
            n_total++;
            $display("FAIL op_while_busy: op %0d issued with busy=1", bus.mdop_E);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic cancel, input logic use_d);
        @(negedge clk);
        bus.mdop_E   = op;
        bus.RS_E     = rs;
        bus.RT_E     = rt;
        bus.cancel_E = cancel;
        bus.mduse_D  = use_d;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    int nb;

    initial begin
        vecs[0] = '{"mult",     MD_MULT,  32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1] = '{"multu",    MD_MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"mult_big", MD_MULT,  32'h0001_0000, 32'h0001_0000, 5,  32'h0000_0001, 32'h0000_0000};
        vecs[3] = '{"div",      MD_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{"divu",     MD_DIVU,  32'd7,         32'd2,         10, 32'h0000_0001, 32'h0000_0003};
        vecs[5] = '{"div_negd", MD_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6] = '{"div_ovf",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[7] = '{"div_zero", MD_DIV,   32'd12345,     32'd0,         10, 32'h0000_0000, 32'h8000_0000};

        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.mdop_E = MD_NONE;
        bus.cancel_E = 1'b0;
        bus.RS_E = '0;
        bus.RT_E = '0;
        bus.mduse_D = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_stall", {31'd0, bus.stall_D}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            bus.mdop_E = MD_NONE;
            count_busy(nb);
            check({vecs[i].name, "_cycles"}, nb, vecs[i].cycles);
            check({vecs[i].name, "_hi"}, bus.HI, vecs[i].hi);
            check({vecs[i].name, "_lo"}, bus.LO, vecs[i].lo);
        end

        // mflo in D behind a mult in E
        issue(MD_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
        #1;
        check("stall_start", {31'd0, bus.stall_D}, 32'd1);
        @(posedge clk);
        #1;
        bus.mdop_E = MD_NONE;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_busy%0d", i), {30'd0, bus.busy, bus.stall_D}, 32'd3);
            @(posedge clk);
            #1;
        end
        check("stall_release", {30'd0, bus.busy, bus.stall_D}, 32'd0);
        check("stall_lo", bus.LO, 32'd12);
        check("stall_hi", bus.HI, 32'd0);

        // cancelled mult never starts
        issue(MD_MULT, 32'd5, 32'd5, 1'b1, 1'b1);
        #1;
        check("cancel_stall", {31'd0, bus.stall_D}, 32'd0);
        @(posedge clk);
        #1;
        check("cancel_busy", {31'd0, bus.busy}, 32'd0);
        check("cancel_lo", bus.LO, 32'd12);
        check("cancel_hi", bus.HI, 32'd0);

        issue(MD_MTHI, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("mthi_hi", bus.HI, 32'h1234_5678);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(MD_MTLO, 32'hCAFE_0001, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("mtlo_cancel", bus.LO, 32'd12);
        issue(MD_MTLO, 32'hCAFE_0001, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("mtlo_lo", bus.LO, 32'hCAFE_0001);
        check("mtlo_hi", bus.HI, 32'h1234_5678);

        // cancel while busy must not abort: divu 100/7 -> q 14 r 2
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.mdop_E = MD_NONE;
        bus.cancel_E = 1'b1;
        count_busy(nb);
        bus.cancel_E = 1'b0;
        check("busy_cancel_cycles", nb, 10);
        check("busy_cancel_lo", bus.LO, 32'd14);
        check("busy_cancel_hi", bus.HI, 32'd2);

        // reset on the 3rd busy cycle of a div
        issue(MD_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.mdop_E = MD_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstmid_busy_before", {31'd0, bus.busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        check("rstmid_hi", bus.HI, 32'd0);
        check("rstmid_lo", bus.LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("rstmid_late_busy", {31'd0, bus.busy}, 32'd0);
        check("rstmid_late_lo", bus.LO, 32'd0);
        check("rstmid_late_hi", bus.HI, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the five-stage MIPS pipeline. It owns the HI/LO registers and sequences the multi-cycle mult/div operations issued from the E stage.
- A latency counter models the iterative unit. While an operation is in flight the block raises a stall to the D stage, so no later HI/LO user can issue.
- It accepts an E-stage cancel so that an instruction squashed by an exception or interrupt never starts and never writes HI/LO.

Parameters:
- MULT_CYCLES, 5: number of busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10: number of busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mdop_E  input  4  MDU operation of the E-stage instruction: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; codes 7..15 are treated as NONE.
- cancel_E  input  1  E-stage instruction is squashed (exception/interrupt). Suppresses any start or write.
- RS_E  input  32  rs operand (already forwarded).
- RT_E  input  32  rt operand (already forwarded).
- mduse_D  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  an operation is in flight.
- stall_D  output  1  freeze F/D and bubble into E.
- HI  output  32  current HI register.
- LO  output  32  current LO register.

Behaviour:
- Reset values: busy=0, HI=0, LO=0, counter=0, pending result=0. stall_D follows the combinational rule below.
- Derived signals:
  - start = (mdop_E in 1..4) & !cancel_E & !busy
  - mtw = (mdop_E in 5..6) & !cancel_E & !busy
- stall_D = mduse_D & (busy | (mdop_E in 1..4 & !cancel_E)). This is purely combinational; it covers the start cycle itself.
- Start at edge T:
  - Compute the result from RS_E/RT_E and latch it in pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; busy=1 from T+1.
- Each busy cycle the counter decrements. At the edge where the counter equals 1, HI/LO <= pending and busy <= 0.
- Result visibility: mfhi/mflo see the new HI/LO in the first cycle with busy=0, i.e. cycle T+N+1, where N is the latency.
- MULT: {HI,LO} = signed 32x32 -> 64-bit product. MULTU: the same, unsigned.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend. DIVU: the same, unsigned.
- Divide by zero: the full DIV_CYCLES busy period still elapses; HI/LO are left unchanged at completion.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- MTHI/MTLO: HI or LO <= RS_E at the same edge, single cycle, no busy period.
- HI/LO outputs are the register values. The E-stage mfhi/mflo mux reads them directly; there is no bypass of pending results.
- While busy, any MDU op in E is ignored (no restart, no mt write). The stall prevents this case; the bench asserts it never occurs.
- cancel_E asserted in a cycle with busy=1 does not abort the in-flight operation. Only reset aborts it.
- Reset mid-operation: everything returns to reset values immediately and the pending result is discarded.
- A counter at 1 while a new start is presented in E cannot happen (busy=1 blocks start). Back-to-back ops therefore always see at least one busy=0 cycle between them.

Decomposition:
- The MDU op codes (MD_NONE..MD_MTLO) become macros in head_def.v, shared with the controller decoder that produces mdop_E and mduse_D.
- One sub-module is natural: mdu_calc. It is combinational and produces the 64-bit {hi,lo} result from op, a and b, including the div-by-zero hold flag.
- The counter, busy flag and HI/LO registers stay in mdu_ctrl.

Test Plan:
- Reset held, then released. Then MULT with RS_E=0xFFFFFFFF, RT_E=2 -> busy=1 for exactly 5 cycles; afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU with RS_E=0xFFFFFFFF, RT_E=2 -> after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7/2 (0xFFFFFFF9, 2) -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV with RT_E=0 -> HI/LO unchanged after 10 cycles.
- MULT in E with mduse_D=1 (mflo in D) -> stall_D=1 in the start cycle and all 5 busy cycles, 0 in the following cycle; mflo then reads the product.
- MULT with cancel_E=1 -> busy stays 0, HI/LO unchanged, stall_D=0. MTHI 0x12345678 with cancel_E=0 -> HI=0x12345678 next cycle.
- Reset asserted on the 3rd busy cycle of DIV -> next cycle busy=0, HI=LO=0; the DIV result never appears.
